pong_ball_engine: RTL and testbench

Parametrised ball-motion engine for the pong datapath: it advances the ball one step per frame tick and reflects it off the top and bottom walls and two paddles. It detects misses, keeps both scores, runs a serve delay between points and stops in a game-over state. It sits between the paddle controllers, which supply `paddle_l_y` and `paddle_r_y`, and the pixel renderer, which consumes `ballx`, `bally` and `ball_visible`. It generalises the fixed single-speed bouncing ball with:
- paddle collision
- a speed ramp
- scoring
- a per-frame update enable

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_axis_step.sv | 42 ++++
 rtl/pong_ball_engine.sv | 199 +++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong types and default geometry.
// Used by the ball engine, the paddle controllers and the renderer.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam int COORD_W_DEF   = 10;
    localparam int SCREEN_W_DEF  = 640;
    localparam int SCREEN_H_DEF  = 480;
    localparam int BALL_SIZE_DEF = 8;
    localparam int PADDLE_H_DEF  = 64;
    localparam int PADDLE_W_DEF  = 8;
    localparam int PADDLE_XL_DEF = 16;
    localparam int PADDLE_XR_DEF = 616;

endpackage

// File: rtl/pong_axis_step.sv
// Combinational single-axis step: pos +/- STEP, then clamp/reflect at 0 and LIMIT.
// Ports: pos/dir (current), pos_next/dir_next (after the step and wall check).
module pong_axis_step
    import pong_pkg::*;
#(
    parameter int W     = 10,
    parameter int LIMIT = 472,
    parameter int STEP  = 1
) (
    input  logic [W-1:0] pos,
    input  dir_t         dir,
    output logic [W-1:0] pos_next,
    output dir_t         dir_next
);

    localparam int SW = W + 2;
    localparam logic signed [SW-1:0] ZERO  = '0;
    localparam logic signed [SW-1:0] LIM_S = SW'(LIMIT);
    localparam logic signed [SW-1:0] STP_S = SW'(STEP);

    logic signed [SW-1:0] base;
    logic signed [SW-1:0] s;

    always_comb begin
        base = signed'({2'b00, pos});
        if (dir == DIR_POS) begin
            s = base + STP_S;
        end else begin
            s = base - STP_S;
        end
        pos_next = s[W-1:0];
        dir_next = dir;
        if (s <= ZERO) begin
            pos_next = '0;
            dir_next = DIR_POS;
        end else if (s >= LIM_S) begin
            pos_next = LIM_S[W-1:0];
            dir_next = DIR_NEG;
        end
    end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: serve delay, motion, wall/paddle reflection, scoring.
// In: clk, rst, frame_tick, paddle_l_y, paddle_r_y. Out: ballx, bally,
// ball_visible, hit, point_l, point_r, score_l, score_r, game_over.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int BALL_SIZE   = BALL_SIZE_DEF,
    parameter int PADDLE_H    = PADDLE_H_DEF,
    parameter int PADDLE_W    = PADDLE_W_DEF,
    parameter int PADDLE_XL   = PADDLE_XL_DEF,
    parameter int PADDLE_XR   = PADDLE_XR_DEF,
    parameter int SPEED_INIT  = 2,
    parameter int SPEED_MAX   = 6,
    parameter int VY          = 1,
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] paddle_l_y,
    input  logic [COORD_W-1:0] paddle_r_y,
    output logic [COORD_W-1:0] ballx,
    output logic [COORD_W-1:0] bally,
    output logic               ball_visible,
    output logic               hit,
    output logic               point_l,
    output logic               point_r,
    output logic [3:0]         score_l,
    output logic [3:0]         score_r,
    output logic               game_over
);

    localparam int SW    = COORD_W + 2;
    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [COORD_W-1:0] CX = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] CY = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] X_HIT_L = COORD_W'(PADDLE_XL + PADDLE_W);
    localparam logic [COORD_W-1:0] X_HIT_R = COORD_W'(PADDLE_XR - BALL_SIZE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SPD_W-1:0]   SPD_INIT = SPD_W'(SPEED_INIT);
    localparam logic [SPD_W-1:0]   SPD_MAX  = SPD_W'(SPEED_MAX);
    localparam logic [3:0]         WIN      = 4'(WIN_SCORE);

    localparam logic signed [SW-1:0] ZERO   = '0;
    localparam logic signed [SW-1:0] EDGE_L = SW'(PADDLE_XL + PADDLE_W);
    localparam logic signed [SW-1:0] EDGE_R = SW'(PADDLE_XR);
    localparam logic signed [SW-1:0] EDGE_S = SW'(SCREEN_W);
    localparam logic signed [SW-1:0] BSZ_S  = SW'(BALL_SIZE);

    state_t state, state_n;
    dir_t   dx, dx_n, dy, dy_n, ny_dir;

    logic [SPD_W-1:0]   speed, speed_n, speed_up;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [COORD_W-1:0] ballx_n, bally_n, ny;
    logic [3:0]         score_l_n, score_r_n;
    logic               hit_n, point_l_n, point_r_n;

    logic signed [SW-1:0] nx, nx_far;
    logic [SW-1:0]        by_w, pl_w, pr_w;
    logic                 ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

    pong_axis_step #(
        .W     (COORD_W),
        .LIMIT (SCREEN_H - BALL_SIZE),
        .STEP  (VY)
    ) u_y (
        .pos      (bally),
        .dir      (dy),
        .pos_next (ny),
        .dir_next (ny_dir)
    );

    always_comb begin
        if (dx == DIR_POS) begin
            nx = signed'({2'b00, ballx}) + signed'(SW'(speed));
        end else begin
            nx = signed'({2'b00, ballx}) - signed'(SW'(speed));
        end
        nx_far = nx + BSZ_S;

        // Overlap uses the pre-move y so a paddle hit is judged where the ball was.
        by_w  = {2'b00, bally};
        pl_w  = {2'b00, paddle_l_y};
        pr_w  = {2'b00, paddle_r_y};
        ovl_l = (by_w + SW'(BALL_SIZE) > pl_w) && (by_w < pl_w + SW'(PADDLE_H));
        ovl_r = (by_w + SW'(BALL_SIZE) > pr_w) && (by_w < pr_w + SW'(PADDLE_H));

        hit_l  = (dx == DIR_NEG) && (nx <= EDGE_L) && ovl_l;
        hit_r  = (dx == DIR_POS) && (nx_far >= EDGE_R) && ovl_r;
        miss_l = (nx <= ZERO);
        miss_r = (nx_far >= EDGE_S);

        speed_up = (speed >= SPD_MAX) ? SPD_MAX : speed + SPD_W'(1);
    end

    always_comb begin
        state_n   = state;
        ballx_n   = ballx;
        bally_n   = bally;
        dx_n      = dx;
        dy_n      = dy;
        speed_n   = speed;
        cnt_n     = cnt;
        score_l_n = score_l;
        score_r_n = score_r;
        hit_n     = 1'b0;
        point_l_n = 1'b0;
        point_r_n = 1'b0;

        if (frame_tick) begin
            unique case (state)
                SERVE: begin
                    if (cnt == CNT_LAST) begin
                        state_n = PLAY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                PLAY: begin
                    bally_n = ny;
                    dy_n    = ny_dir;
                    if (hit_l || hit_r) begin
                        ballx_n = hit_l ? X_HIT_L : X_HIT_R;
                        dx_n    = hit_l ? DIR_POS : DIR_NEG;
                        speed_n = speed_up;
                        hit_n   = 1'b1;
                    end else if (miss_l || miss_r) begin
                        // A miss wins over a same-tick wall bounce: y recentres, dy kept.
                        if (miss_l) begin
                            score_r_n = score_r + 4'd1;
                            point_r_n = 1'b1;
                            dx_n      = DIR_NEG;
                        end else begin
                            score_l_n = score_l + 4'd1;
                            point_l_n = 1'b1;
                            dx_n      = DIR_POS;
                        end
                        ballx_n = CX;
                        bally_n = CY;
                        dy_n    = dy;
                        speed_n = SPD_INIT;
                        if (score_l_n == WIN || score_r_n == WIN) begin
                            state_n = GAME_OVER;
                        end else begin
                            state_n = SERVE;
                        end
                    end else begin
                        ballx_n = nx[COORD_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SERVE;
            ballx        <= CX;
            bally        <= CY;
            dx           <= DIR_POS;
            dy           <= DIR_POS;
            speed        <= SPD_INIT;
            cnt          <= '0;
            score_l      <= '0;
            score_r      <= '0;
            hit          <= 1'b0;
            point_l      <= 1'b0;
            point_r      <= 1'b0;
            ball_visible <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            ballx        <= ballx_n;
            bally        <= bally_n;
            dx           <= dx_n;
            dy           <= dy_n;
            speed        <= speed_n;
            cnt          <= cnt_n;
            score_l      <= score_l_n;
            score_r      <= score_r_n;
            hit          <= hit_n;
            point_l      <= point_l_n;
            point_r      <= point_r_n;
            ball_visible <= (state_n == PLAY);
            game_over    <= (state_n == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomised bench for pong_ball_engine against an integer game model.
// Drives ticks and paddles, compares every output after every clock edge.
module tb_pong_ball_engine;

    localparam int SD   = 2;
    localparam int CXI  = 316;
    localparam int CYI  = 236;
    localparam int YMAX = 472;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic [9:0] paddle_l_y;
    logic [9:0] paddle_r_y;
    logic [9:0] ballx;
    logic [9:0] bally;
    logic       ball_visible;
    logic       hit;
    logic       point_l;
    logic       point_r;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;

    pong_ball_engine #(.SERVE_DELAY(SD)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .paddle_l_y   (paddle_l_y),
        .paddle_r_y   (paddle_r_y),
        .ballx        (ballx),
        .bally        (bally),
        .ball_visible (ball_visible),
        .hit          (hit),
        .point_l      (point_l),
        .point_r      (point_r),
        .score_l      (score_l),
        .score_r      (score_r),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: state 0=serve 1=play 2=over; directions are +1/-1.
    int m_state, m_bx, m_by, m_dx, m_dy, m_spd, m_cnt, m_sl, m_sr;
    bit m_hit, m_pl, m_pr;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_step(input bit r, input bit t, input int pl, input int pr);
        int nx;
        int ny;
        int nyy;
        int ndy;
        bit hl;
        bit hr;
        m_hit = 0;
        m_pl  = 0;
        m_pr  = 0;
        if (r) begin
            m_state = 0; m_bx = CXI; m_by = CYI; m_dx = 1; m_dy = 1;
            m_spd = 2; m_cnt = 0; m_sl = 0; m_sr = 0;
            return;
        end
        if (!t) return;
        if (m_state == 0) begin
            if (m_cnt == SD - 1) begin
                m_state = 1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end else if (m_state == 1) begin
            nx  = m_bx + m_dx * m_spd;
            ny  = m_by + m_dy;
            nyy = ny;
            ndy = m_dy;
            if (ny <= 0) begin
                nyy = 0; ndy = 1;
            end else if (ny >= YMAX) begin
                nyy = YMAX; ndy = -1;
            end
            hl = (m_dx < 0) && (nx <= 24) && (m_by + 8 > pl) && (m_by < pl + 64);
            hr = (m_dx > 0) && (nx + 8 >= 616) && (m_by + 8 > pr) && (m_by < pr + 64);
            if (hl || hr) begin
                m_bx  = hl ? 24 : 608;
                m_dx  = -m_dx;
                m_spd = (m_spd + 1 > 6) ? 6 : m_spd + 1;
                m_hit = 1;
                m_by  = nyy;
                m_dy  = ndy;
            end else if (nx <= 0 || nx + 8 >= 640) begin
                if (nx <= 0) begin
                    m_sr++; m_pr = 1; m_dx = -1;
                end else begin
                    m_sl++; m_pl = 1; m_dx = 1;
                end
                m_bx  = CXI;
                m_by  = CYI;
                m_spd = 2;
                m_state = (m_sl == 9 || m_sr == 9) ? 2 : 0;
            end else begin
                m_bx = nx;
                m_by = nyy;
                m_dy = ndy;
            end
        end
    endtask

    task automatic check_all();
        chk("ballx", int'(ballx), m_bx);
        chk("bally", int'(bally), m_by);
        chk("visible", int'(ball_visible), int'(m_state == 1));
        chk("hit", int'(hit), int'(m_hit));
        chk("point_l", int'(point_l), int'(m_pl));
        chk("point_r", int'(point_r), int'(m_pr));
        chk("score_l", int'(score_l), m_sl);
        chk("score_r", int'(score_r), m_sr);
        chk("game_over", int'(game_over), int'(m_state == 2));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(rst, frame_tick, int'(paddle_l_y), int'(paddle_r_y));
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [9:0] trk(input int off);
        int v;
        v = m_by - off;
        if (v < 0) v = 0;
        return 10'(v);
    endfunction

    function automatic logic [9:0] dodge();
        return (m_by < 200) ? 10'd400 : 10'd0;
    endfunction

    initial begin
        int hits;
        bit done;
        rst        = 1'b1;
        frame_tick = 1'b0;
        paddle_l_y = 10'd400;
        paddle_r_y = 10'd400;
        cyc();
        rst = 1'b0;

        // Serve delay then first step.
        frame_tick = 1'b1;
        cyc();
        cyc();
        chk("t1_vis", int'(ball_visible), 1);
        chk("t1_x", int'(ballx), 316);
        chk("t1_y", int'(bally), 236);
        cyc();
        chk("t1_x2", int'(ballx), 318);
        chk("t1_y2", int'(bally), 237);

        // Free run with parked paddles until a point.
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            frame_tick = ($urandom_range(0, 3) != 0);
            cyc();
            if (m_pl || m_pr) done = 1;
        end
        chk("t2_done", int'(done), 1);
        chk("t2_pulse", int'(point_l) + int'(point_r), 1);
        chk("t2_score", int'(score_l) + int'(score_r), 1);
        chk("t2_x", int'(ballx), 316);
        frame_tick = 1'b0;
        cyc();
        chk("t2_once", int'(point_l) + int'(point_r), 0);

        // Right paddle tracks: first hit at 608, speed 3 afterwards.
        do_reset();
        frame_tick = 1'b1;
        paddle_l_y = 10'd400;
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            paddle_r_y = trk(20);
            cyc();
            if (m_hit) done = 1;
        end
        chk("t3_done", int'(done), 1);
        chk("t3_hit", int'(hit), 1);
        chk("t3_hitx", int'(ballx), 608);
        paddle_r_y = trk(20);
        cyc();
        chk("t3_nohit", int'(hit), 0);
        chk("t3_next", int'(ballx), 605);

        // Both paddles track: long rally, speed ramps and saturates.
        do_reset();
        hits = 0;
        for (int i = 0; i < 8000 && hits < 12; i++) begin
            frame_tick = ($urandom_range(0, 4) != 0);
            paddle_l_y = trk($urandom_range(0, 50));
            paddle_r_y = trk($urandom_range(0, 50));
            cyc();
            if (m_hit) hits++;
        end
        chk("t4_rallies", int'(hits >= 12), 1);
        chk("t4_noscore", int'(score_l) + int'(score_r), 0);

        // Left always misses: right wins 9-0.
        do_reset();
        frame_tick = 1'b1;
        done = 0;
        for (int i = 0; i < 8000 && !done; i++) begin
            paddle_l_y = dodge();
            paddle_r_y = trk($urandom_range(0, 50));
            cyc();
            if (m_state == 2) done = 1;
        end
        chk("t5_done", int'(done), 1);
        chk("t5_sr", int'(score_r), 9);
        chk("t5_sl", int'(score_l), 0);
        chk("t5_over", int'(game_over), 1);
        for (int i = 0; i < 6; i++) cyc();
        chk("t5_frozen", int'(score_r), 9);
        chk("t5_x", int'(ballx), 316);
        chk("t5_vis", int'(ball_visible), 0);
        do_reset();
        chk("t5_rst_sr", int'(score_r), 0);
        chk("t5_rst_over", int'(game_over), 0);

        // Reset together with a tick mid-play.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < int'($urandom_range(3, 120)); i++) begin
                frame_tick = ($urandom_range(0, 3) != 0);
                paddle_l_y = trk($urandom_range(0, 50));
                paddle_r_y = 10'($urandom_range(0, 472));
                cyc();
            end
            frame_tick = 1'b1;
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            chk("t6_x", int'(ballx), 316);
            chk("t6_y", int'(bally), 236);
            chk("t6_vis", int'(ball_visible), 0);
            chk("t6_pulses", int'(hit) + int'(point_l) + int'(point_r), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
